// File: rtl/pre_emphasis.sv
// Streaming first-order pre-emphasis filter y[n] = x[n] - COEF*x[n-1] / 2^FRAC, two-edge latency.
// Define PREEMPHASIS_ROUND_EN to round the scaled term half toward +inf instead of flooring it.
module pre_emphasis #(
    parameter int I_BW = 16,
    parameter int O_BW = 17,
    parameter int COEF = 31785,
    parameter int FRAC = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [I_BW-1:0] data_i,
    output logic            valid_o,
    output logic [O_BW-1:0] data_o
);

    localparam int PW = I_BW + FRAC + 2;
    // Difference width wide enough for both x - scaled and the saturation check.
    localparam int DW = (O_BW + 1 > I_BW + 3) ? O_BW + 1 : I_BW + 3;
    localparam logic signed [PW-1:0] COEF_S   = PW'(COEF);
    localparam logic [PW:0]          RND_HALF = (PW + 1)'(1) << (FRAC - 1);

    logic signed [I_BW-1:0] r_x_prev;
    logic signed [I_BW-1:0] r_x_p1;
    logic signed [PW-1:0]   r_prod_p1;
    logic                   r_vld_p1;
    logic signed [O_BW-1:0] r_data_p2;
    logic                   r_vld_p2;

    logic signed [PW-1:0] w_xprev_ext;
    logic signed [PW-1:0] w_prod;
    logic signed [PW:0]   w_prod_adj;
    logic signed [PW:0]   w_shift;
    logic signed [DW-1:0] w_scaled;
    logic signed [DW-1:0] w_xs1_ext;
    logic signed [DW-1:0] w_diff;
    logic                 w_unused_hi;

    function automatic logic signed [O_BW-1:0] sat_o(input logic signed [DW-1:0] v);
        if (v[DW-1:O_BW-1] == {(DW - O_BW + 1){v[DW-1]}})
            return v[O_BW-1:0];
        else if (v[DW-1])
            return {1'b1, {(O_BW - 1){1'b0}}};
        else
            return {1'b0, {(O_BW - 1){1'b1}}};
    endfunction

    assign w_xprev_ext = {{(PW - I_BW){r_x_prev[I_BW-1]}}, r_x_prev};
    assign w_prod      = COEF_S * w_xprev_ext;

`ifdef PREEMPHASIS_ROUND_EN
    assign w_prod_adj = {r_prod_p1[PW-1], r_prod_p1} + RND_HALF;
`else
    assign w_prod_adj = {r_prod_p1[PW-1], r_prod_p1};
`endif

    // Arithmetic shift keeps floor semantics for negative products.
    assign w_shift     = w_prod_adj >>> FRAC;
    assign w_scaled    = w_shift[DW-1:0];
    assign w_unused_hi = ^w_shift[PW:DW];
    assign w_xs1_ext   = {{(DW - I_BW){r_x_p1[I_BW-1]}}, r_x_p1};
    assign w_diff      = w_xs1_ext - w_scaled;

    // Stage 1: capture sample and exact product against history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_prev  <= '0;
            r_x_p1    <= '0;
            r_prod_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= valid_i;
            if (valid_i) begin
                r_x_p1    <= data_i;
                r_prod_p1 <= w_prod;
                r_x_prev  <= data_i;
            end
        end
    end

    // Stage 2: scale, subtract, saturate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_p2 <= '0;
            r_vld_p2  <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1)
                r_data_p2 <= sat_o(w_diff);
        end
    end

    assign valid_o = r_vld_p2;
    assign data_o  = r_data_p2;

endmodule

// File: tb/tb_pre_emphasis.sv
// Bench for pre_emphasis: directed cases from the filter's definition plus randomized traffic
// checked against an arithmetic reference of y = x - alpha*x_prev with two-edge latency.
module tb_pre_emphasis;

    localparam int I_BW = 16;
    localparam int O_BW = 17;
    localparam int COEF = 31785;
    localparam int FRAC = 15;

    logic            clk;
    logic            rst_n;
    logic            valid_i;
    logic [I_BW-1:0] data_i;
    logic            valid_o;
    logic [O_BW-1:0] data_o;

    int nvec = 0;
    int nerr = 0;

    // Reference state: history, the result in flight, and the value held on the output
    int m_xprev = 0;
    bit m_pv    = 0;
    int m_py    = 0;
    int m_hold  = 0;

    pre_emphasis #(
        .I_BW(I_BW), .O_BW(O_BW), .COEF(COEF), .FRAC(FRAC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid_i(valid_i),
        .data_i (data_i),
        .valid_o(valid_o),
        .data_o (data_o)
    );

    always #5 clk = ~clk;

    function automatic int ref_y(input int x, input int xp);
        longint den;
        longint num;
        longint q;
        longint y;
        longint omax;
        den  = longint'(1) << FRAC;
        omax = (longint'(1) << (O_BW - 1)) - 1;
        num  = longint'(COEF) * longint'(xp);
`ifdef PREEMPHASIS_ROUND_EN
        num = num + den / 2;
`endif
        q = num / den;
        if ((num % den != 0) && (num < 0))
            q = q - 1;
        y = longint'(x) - q;
        if (y > omax)
            y = omax;
        if (y < -omax - 1)
            y = -omax - 1;
        return int'(y);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered just after a falling edge; drives one cycle and checks the outputs after the rising edge.
    task automatic step(input bit v, input int d);
        int dv;
        dv      = v ? d : int'($urandom);
        valid_i = v;
        data_i  = dv[I_BW-1:0];
        @(posedge clk);
        #1;
        if (m_pv)
            m_hold = m_py;
        chk("valid_o", int'(valid_o), int'(m_pv));
        chk("data_o", int'($signed(data_o)), m_hold);
        if (v) begin
            m_py    = ref_y(d, m_xprev);
            m_xprev = d;
        end
        m_pv = v;
        @(negedge clk);
    endtask

    task automatic do_reset();
        valid_i = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst_valid_async", int'(valid_o), 0);
        chk("rst_data_async", int'($signed(data_o)), 0);
        @(posedge clk);
        #1;
        chk("rst_valid_hold", int'(valid_o), 0);
        chk("rst_data_hold", int'($signed(data_o)), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_xprev = 0;
        m_pv    = 0;
        m_py    = 0;
        m_hold  = 0;
    endtask

    initial begin
        int d;
        bit v;
        clk     = 1'b0;
        rst_n   = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        @(negedge clk);
        do_reset();

        // Step response
        step(1, 1000);
        step(1, 1000);
        chk("step_y0", int'($signed(data_o)), 1000);
        step(0, 0);
        chk("step_y1", int'($signed(data_o)), 30);
        step(0, 0);

        // Extremes
        do_reset();
        step(1, -32768);
        step(1, 0);
        chk("ext_y0", int'($signed(data_o)), -32768);
        step(1, 0);
        chk("ext_y1", int'($signed(data_o)), 31785);
        step(1, 32767);
        chk("ext_y2", int'($signed(data_o)), 0);
        step(1, -32768);
        chk("ext_y3", int'($signed(data_o)), 32767);
        step(0, 0);
        chk("ext_y4", int'($signed(data_o)), -64552);

        // Rounding mode
        do_reset();
        step(1, 1);
        step(1, 0);
        chk("rnd_y0", int'($signed(data_o)), 1);
        step(0, 0);
`ifdef PREEMPHASIS_ROUND_EN
        chk("rnd_y1", int'($signed(data_o)), -1);
`else
        chk("rnd_y1", int'($signed(data_o)), 0);
`endif

        // Valid gaps with garbage data
        do_reset();
        step(1, 1000);
        step(0, 0);
        chk("gap_y0", int'($signed(data_o)), 1000);
        step(0, 0);
        chk("gap_hold1", int'($signed(data_o)), 1000);
        step(0, 0);
        chk("gap_hold2", int'($signed(data_o)), 1000);
        step(1, 1000);
        chk("gap_hold3", int'(valid_o), 0);
        step(0, 0);
        chk("gap_y1", int'($signed(data_o)), 30);

        // Reset mid-stream clears history and the in-flight sample
        do_reset();
        step(1, 1000);
        do_reset();
        step(1, 1000);
        chk("mid_novalid", int'(valid_o), 0);
        step(0, 0);
        chk("mid_y0", int'($signed(data_o)), 1000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       d = -32768;
                1:       d = 32767;
                2:       d = int'($urandom_range(0, 8)) - 4;
                default: d = int'($urandom_range(0, 65535)) - 32768;
            endcase
            if ($urandom_range(0, 99) == 0)
                do_reset();
            step(v, d);
        end
        step(0, 0);
        step(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pre_emphasis.md
# pre_emphasis

Streaming first-order pre-emphasis FIR filter, y[n] = x[n] − α·x[n−1], for the front end of the log-mel-spectrogram pipeline. It accepts one signed PCM sample per valid cycle and emits the filtered sample, one bit wider, two clock edges later. It sits between the audio sample source and the framing/windowing stage, with no backpressure.

## Interface
- I_BW, 16: input sample width, signed two's complement.
- O_BW, 17: output width, signed; must be ≥ I_BW+1 for lossless results.
- COEF, 31785: α in unsigned Q(FRAC) format (≈0.97).
- FRAC, 15: fractional bits of COEF.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low; clock clk.
- valid_i  in  1  data_i carries a new sample this cycle.
- data_i  in  I_BW  signed input sample x[n].
- valid_o  out  1  data_o carries a new filtered sample this cycle.
- data_o  out  O_BW  signed filtered sample y[n].

## Operation
- History register x_prev holds the last accepted sample. It resets to 0, so the first sample after reset gives y = x.
- History updates only on edges with valid_i=1. Cycles with valid_i=0 leave the history and the filter state unchanged.
- Stage 1, on an accepting edge:
  - register x_s1 = data_i;
  - register prod = COEF × x_prev as a signed product of I_BW+FRAC+2 bits, exact;
  - set x_prev ← data_i;
  - v1 ← valid_i, updated every edge.
- Stage 2, on an edge with v1=1:
  - scaled = prod >>> FRAC, arithmetic shift (floor);
  - diff = x_s1 − scaled, computed at full width;
  - data_o ← diff saturated to the O_BW signed range.
  - At defaults no saturation can occur; the bound is |y| ≤ 65535.
- valid_o ← v1 on every edge.
- data_o holds its last value whenever valid_o=0.
- No ready or stall input. Full throughput: one sample per cycle, back-to-back allowed.

## Timing
- Reset (asynchronous, immediate):
  - clears x_prev, x_s1, prod, v1, valid_o and data_o to 0;
  - reset mid-stream discards all in-flight samples and history.
- Reset release: the first edge with rst_n=1 may accept a sample.
- Latency: a sample accepted at edge k appears on data_o with valid_o=1 after edge k+1, and stays valid until edge k+2.
- valid_o is a one-cycle pulse per accepted sample. Gaps in valid_i reproduce as identical gaps on valid_o, delayed by one edge.
- data_i is sampled only at edges where valid_i=1. It is don't-care otherwise, including X or Z.

## Configuration
- PREEMPHASIS_ROUND_EN:
  - Defined: scaled = (prod + 2^(FRAC−1)) >>> FRAC, i.e. round half toward +∞.
  - Undefined (default): scaled = prod >>> FRAC, i.e. floor.
- Latency, handshake and saturation are identical in both builds.

## Test plan
- Reset state: assert rst_n=0 with clk running → valid_o=0 and data_o=0 immediately. Both hold until the first accepted sample has propagated through the pipeline.
- Step response: after reset, feed x = 1000, 1000 → y = 1000, then 30 (scaled = floor(31785000/32768) = 970). valid_o asserts after edges k+1 and k+2.
- Extremes: feed −32768, 0, 0 → y = −32768, 31785, 0. Then feed 32767, −32768 → second output y = −64552, within 17-bit range with no saturation.
- Rounding macro: feed 1, 0 → second output is y = 0 without PREEMPHASIS_ROUND_EN and y = −1 with it.
- Valid gaps: feed 1000, then 3 idle cycles with data_i toggling garbage, then 1000 → outputs 1000 and 30. valid_o is low for exactly 3 cycles between them and data_o holds 1000 during the gap.
- Reset mid-stream: feed 1000, assert rst_n low for one cycle, release, feed 1000 → output 1000, showing the history was cleared. No stale valid_o pulse appears after release.
